hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait stalls, branch
// flushes, operand forwarding selects and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned LD_LAT  = 1,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D_valid,
    input  logic              D_ra_used,
    input  logic              D_rb_used,
    input  logic [REG_AW-1:0] D_ra,
    input  logic [REG_AW-1:0] D_rb,
    input  logic              EX_valid,
    input  logic              EX_we,
    input  logic              EX_ld,
    input  logic [REG_AW-1:0] EX_rd,
    input  logic              MEM_valid,
    input  logic              MEM_we,
    input  logic              MEM_ld,
    input  logic              MEM_str,
    input  logic              mem_busy,
    input  logic [REG_AW-1:0] MEM_rd,
    input  logic              WB_valid,
    input  logic              WB_we,
    input  logic [REG_AW-1:0] WB_rd,
    input  logic              EX_taken,
    output logic              pc_stall,
    output logic              fd_stall,
    output logic              dx_stall,
    output logic              xm_stall,
    output logic              fd_flush,
    output logic              dx_bubble,
    output logic              mw_bubble,
    output logic [1:0]        EX_fwd_a,
    output logic [1:0]        EX_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state
);

    localparam int unsigned LAT_W    = 3;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LD_LAT - 1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_LUSTALL = 2'd1;
    localparam logic [1:0] S_MEMWAIT = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [1:0]       fwd_a_q, fwd_b_q;
    logic [1:0]       sel_a, sel_b;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // A valid writing producer targets a register Decode actually reads.
    function automatic logic src_match(
        input logic              dv,
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              pv,
        input logic              pwe,
        input logic [REG_AW-1:0] prd
    );
        return dv && used && pv && pwe && (src == prd) &&
               ((R0_ZERO == 0) || (src != '0));
    endfunction

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic load_use, mem_wait, br_req;

    // Hazard detection terms shared by the FSM and forwarding logic.
    always_comb begin
        ex_a     = src_match(D_valid, D_ra_used, D_ra, EX_valid,  EX_we,  EX_rd);
        ex_b     = src_match(D_valid, D_rb_used, D_rb, EX_valid,  EX_we,  EX_rd);
        mem_a    = src_match(D_valid, D_ra_used, D_ra, MEM_valid, MEM_we, MEM_rd);
        mem_b    = src_match(D_valid, D_rb_used, D_rb, MEM_valid, MEM_we, MEM_rd);
        wb_a     = src_match(D_valid, D_ra_used, D_ra, WB_valid,  WB_we,  WB_rd);
        wb_b     = src_match(D_valid, D_rb_used, D_rb, WB_valid,  WB_we,  WB_rd);
        load_use = EX_ld && (ex_a || ex_b);
        mem_wait = (MEM_ld || MEM_str) && MEM_valid && mem_busy;
        br_req   = EX_taken || pend_q;
    end

    // FSM state, load-use down-counter and deferred-branch bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next state: memory wait beats branch beats load-use; branches seen
    // outside RUN are parked in pend and taken once back in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            S_RUN: begin
                if (mem_wait) begin
                    state_d = S_MEMWAIT;
                    pend_d  = pend_q || EX_taken;
                end else if (br_req) begin
                    state_d = S_FLUSH;
                    pend_d  = 1'b0;
                end else if (load_use) begin
                    state_d = S_LUSTALL;
                    cnt_d   = LAT_INIT;
                end
            end
            S_LUSTALL: begin
                pend_d = pend_q || EX_taken;
                if (mem_wait) begin
                    state_d = S_MEMWAIT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MEMWAIT: begin
                pend_d = pend_q || EX_taken;
                if (!mem_busy) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                pend_d  = pend_q || EX_taken;
                state_d = mem_wait ? S_MEMWAIT : S_RUN;
            end
        endcase
    end

    // Pipeline control outputs, combinational from state and inputs; quiet in reset.
    always_comb begin
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        dx_stall  = 1'b0;
        xm_stall  = 1'b0;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        mw_bubble = 1'b0;
        if (rst) begin
            case (state_q)
                S_RUN: begin
                    if (mem_wait) begin
                        {pc_stall, fd_stall, dx_stall, xm_stall, mw_bubble} = 5'b11111;
                    end else if (br_req) begin
                        {fd_flush, dx_bubble} = 2'b11;
                    end else if (load_use) begin
                        {pc_stall, fd_stall, dx_bubble} = 3'b111;
                    end
                end
                S_LUSTALL: begin
                    if (mem_wait) begin
                        {pc_stall, fd_stall, dx_stall, xm_stall, mw_bubble} = 5'b11111;
                    end else if (cnt_q != '0) begin
                        {pc_stall, fd_stall, dx_bubble} = 3'b111;
                    end
                end
                S_MEMWAIT: begin
                    if (mem_busy) begin
                        {pc_stall, fd_stall, dx_stall, xm_stall, mw_bubble} = 5'b11111;
                    end
                end
                default: begin
                    if (mem_wait) begin
                        {pc_stall, fd_stall, dx_stall, xm_stall, mw_bubble} = 5'b11111;
                    end
                end
            endcase
        end
    end

    // Forwarding select, nearest producer first.
    always_comb begin
        sel_a = ex_a ? 2'd1 : mem_a ? 2'd2 : wb_a ? 2'd3 : 2'd0;
        sel_b = ex_b ? 2'd1 : mem_b ? 2'd2 : wb_b ? 2'd3 : 2'd0;
    end

    // Forwarding selects travel with the D/EX register.
    always_ff @(posedge clk) begin
        if (!rst || dx_bubble) begin
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
        end else if (!dx_stall) begin
            fwd_a_q <= sel_a;
            fwd_b_q <= sel_b;
        end
    end

    // Saturating stall and flush counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fd_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign EX_fwd_a  = fwd_a_q;
    assign EX_fwd_b  = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expectations are queued as
// stimulus is driven and compared at the following falling edge.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;
    localparam logic [1:0] S_FL  = 2'd3;

    // {pc_stall, fd_stall, dx_stall, xm_stall, fd_flush, dx_bubble, mw_bubble}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_MW   = 7'b1111001;
    localparam logic [6:0] C_FL   = 7'b0000110;

    logic clk = 1'b0;
    logic rst;
    logic D_valid, D_ra_used, D_rb_used;
    logic [AW-1:0] D_ra, D_rb, EX_rd, MEM_rd, WB_rd;
    logic EX_valid, EX_we, EX_ld;
    logic MEM_valid, MEM_we, MEM_ld, MEM_str, mem_busy;
    logic WB_valid, WB_we, EX_taken;

    logic pc_stall, fd_stall, dx_stall, xm_stall, fd_flush, dx_bubble, mw_bubble;
    logic [1:0] EX_fwd_a, EX_fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc, s_fd, s_dx, s_xm, s_ff, s_db, s_mb;
    logic [1:0] s_fa, s_fb, s_state;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .LD_LAT(2), .CNT_W(16), .R0_ZERO(1)) dut (
        .clk(clk), .rst(rst),
        .D_valid(D_valid), .D_ra_used(D_ra_used), .D_rb_used(D_rb_used),
        .D_ra(D_ra), .D_rb(D_rb),
        .EX_valid(EX_valid), .EX_we(EX_we), .EX_ld(EX_ld), .EX_rd(EX_rd),
        .MEM_valid(MEM_valid), .MEM_we(MEM_we), .MEM_ld(MEM_ld), .MEM_str(MEM_str),
        .mem_busy(mem_busy), .MEM_rd(MEM_rd),
        .WB_valid(WB_valid), .WB_we(WB_we), .WB_rd(WB_rd),
        .EX_taken(EX_taken),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .dx_stall(dx_stall), .xm_stall(xm_stall),
        .fd_flush(fd_flush), .dx_bubble(dx_bubble), .mw_bubble(mw_bubble),
        .EX_fwd_a(EX_fwd_a), .EX_fwd_b(EX_fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    // Narrow-counter instance to exercise saturation.
    hazard_ctrl #(.REG_AW(AW), .LD_LAT(2), .CNT_W(2), .R0_ZERO(1)) dut_sat (
        .clk(clk), .rst(rst),
        .D_valid(D_valid), .D_ra_used(D_ra_used), .D_rb_used(D_rb_used),
        .D_ra(D_ra), .D_rb(D_rb),
        .EX_valid(EX_valid), .EX_we(EX_we), .EX_ld(EX_ld), .EX_rd(EX_rd),
        .MEM_valid(MEM_valid), .MEM_we(MEM_we), .MEM_ld(MEM_ld), .MEM_str(MEM_str),
        .mem_busy(mem_busy), .MEM_rd(MEM_rd),
        .WB_valid(WB_valid), .WB_we(WB_we), .WB_rd(WB_rd),
        .EX_taken(EX_taken),
        .pc_stall(s_pc), .fd_stall(s_fd), .dx_stall(s_dx), .xm_stall(s_xm),
        .fd_flush(s_ff), .dx_bubble(s_db), .mw_bubble(s_mb),
        .EX_fwd_a(s_fa), .EX_fwd_b(s_fb),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state(s_state)
    );

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic [1:0]  fa;
        logic [1:0]  fb;
        int unsigned sc;
        int unsigned fc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned checks;
    int unsigned failures;
    int unsigned e_sc, e_fc;
    logic [1:0]  e_fa, e_fb;
    logic [6:0]  ctrl_vec;

    assign ctrl_vec = {pc_stall, fd_stall, dx_stall, xm_stall, fd_flush, dx_bubble, mw_bubble};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    // Compare the oldest queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_eq({mon_e.tag, ".ctrl"},  32'(ctrl_vec),    32'(mon_e.ctrl));
            check_eq({mon_e.tag, ".state"}, 32'(state),       32'(mon_e.st));
            check_eq({mon_e.tag, ".fwd_a"}, 32'(EX_fwd_a),    32'(mon_e.fa));
            check_eq({mon_e.tag, ".fwd_b"}, 32'(EX_fwd_b),    32'(mon_e.fb));
            check_eq({mon_e.tag, ".scnt"},  32'(stall_cnt),   mon_e.sc);
            check_eq({mon_e.tag, ".fcnt"},  32'(flush_cnt),   mon_e.fc);
            check_eq({mon_e.tag, ".sat_s"}, 32'(s_stall_cnt), sat3(mon_e.sc));
            check_eq({mon_e.tag, ".sat_f"}, 32'(s_flush_cnt), sat3(mon_e.fc));
        end
    end

    task automatic clr();
        D_valid = 0; D_ra_used = 0; D_rb_used = 0; D_ra = '0; D_rb = '0;
        EX_valid = 0; EX_we = 0; EX_ld = 0; EX_rd = '0;
        MEM_valid = 0; MEM_we = 0; MEM_ld = 0; MEM_str = 0; mem_busy = 0; MEM_rd = '0;
        WB_valid = 0; WB_we = 0; WB_rd = '0; EX_taken = 0;
    endtask

    // Queue this cycle's expectation, then advance one clock.
    task automatic cyc(input string tag, input logic [6:0] c, input logic [1:0] st);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.st = st;
        e.fa = e_fa; e.fb = e_fb; e.sc = e_sc; e.fc = e_fc;
        sb.push_back(e);
        if (!rst) begin
            e_sc = 0;
            e_fc = 0;
        end else begin
            e_sc = e_sc + 32'(c[6]);
            e_fc = e_fc + 32'(c[2]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        D_valid = 1; D_ra_used = 1; D_ra = 5'd3;
        EX_valid = 1; EX_we = 1; EX_ld = 1; EX_rd = 5'd3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        e_sc = 0; e_fc = 0; e_fa = 2'd0; e_fb = 2'd0;
        clr();
        rst = 0;
        EX_taken = 1;
        @(posedge clk);
        #1;
        cyc("rst_hold", C_NONE, S_RUN);
        rst = 1; clr();
        cyc("idle", C_NONE, S_RUN);

        // Forwarding priority EX > MEM > WB
        D_valid = 1; D_rb_used = 1; D_rb = 5'd4;
        EX_valid = 1; EX_we = 1; EX_rd = 5'd4;
        MEM_valid = 1; MEM_we = 1; MEM_rd = 5'd4;
        cyc("fwd_ex", C_NONE, S_RUN);
        EX_valid = 0; MEM_valid = 0; WB_valid = 1; WB_we = 1; WB_rd = 5'd4; e_fb = 2'd1;
        cyc("fwd_wb", C_NONE, S_RUN);
        WB_valid = 0; MEM_valid = 1; D_ra_used = 1; D_ra = 5'd4; e_fb = 2'd3;
        cyc("fwd_mem", C_NONE, S_RUN);
        clr(); e_fa = 2'd2; e_fb = 2'd2;
        cyc("fwd_clr", C_NONE, S_RUN);
        e_fa = 2'd0; e_fb = 2'd0;

        // Register 0 never a hazard
        D_valid = 1; D_ra_used = 1; D_ra = '0;
        EX_valid = 1; EX_we = 1; EX_ld = 1; EX_rd = '0;
        cyc("r0", C_NONE, S_RUN);
        clr();
        cyc("r0_fwd", C_NONE, S_RUN);

        // Load-use, two stall cycles
        set_load_use();
        cyc("lu0", C_LU, S_RUN);
        EX_valid = 0;
        cyc("lu1", C_LU, S_LU);
        cyc("lu2", C_NONE, S_LU);
        clr();
        cyc("lu_done", C_NONE, S_RUN);

        // Memory wait, busy for three cycles
        MEM_valid = 1; MEM_ld = 1; mem_busy = 1;
        cyc("mw0", C_MW, S_RUN);
        cyc("mw1", C_MW, S_MW);
        cyc("mw2", C_MW, S_MW);
        mem_busy = 0;
        cyc("mw3", C_NONE, S_MW);
        clr();
        cyc("mw4", C_NONE, S_RUN);

        // Branch during memory wait is deferred
        MEM_valid = 1; MEM_str = 1; mem_busy = 1;
        cyc("bm0", C_MW, S_RUN);
        EX_taken = 1;
        cyc("bm1", C_MW, S_MW);
        EX_taken = 0; mem_busy = 0;
        cyc("bm2", C_NONE, S_MW);
        clr();
        cyc("bm3", C_FL, S_RUN);
        cyc("bm4", C_NONE, S_FL);
        cyc("bm5", C_NONE, S_RUN);

        // Plain taken branch
        EX_taken = 1;
        cyc("br0", C_FL, S_RUN);
        clr();
        cyc("br1", C_NONE, S_FL);
        cyc("br2", C_NONE, S_RUN);

        // Branch outranks load-use
        set_load_use(); EX_taken = 1;
        cyc("pb0", C_FL, S_RUN);
        clr();
        cyc("pb1", C_NONE, S_FL);
        cyc("pb2", C_NONE, S_RUN);

        // Memory wait outranks a simultaneous branch
        MEM_valid = 1; MEM_ld = 1; mem_busy = 1; EX_taken = 1;
        cyc("pm0", C_MW, S_RUN);
        EX_taken = 0; mem_busy = 0;
        cyc("pm1", C_NONE, S_MW);
        clr();
        cyc("pm2", C_FL, S_RUN);
        cyc("pm3", C_NONE, S_FL);
        cyc("pm4", C_NONE, S_RUN);

        // Reset in the middle of a load-use stall
        set_load_use();
        cyc("rl0", C_LU, S_RUN);
        EX_valid = 0; rst = 0;
        cyc("rl1", C_NONE, S_LU);
        rst = 1; clr();
        cyc("rl2", C_NONE, S_RUN);
        cyc("rl3", C_NONE, S_RUN);

        // Reset during memory wait drops a deferred branch
        MEM_valid = 1; MEM_ld = 1; mem_busy = 1;
        cyc("rm0", C_MW, S_RUN);
        EX_taken = 1;
        cyc("rm1", C_MW, S_MW);
        EX_taken = 0; rst = 0;
        cyc("rm2", C_NONE, S_MW);
        rst = 1; clr();
        cyc("rm3", C_NONE, S_RUN);
        cyc("rm4", C_NONE, S_RUN);

        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
